// File: rtl/dab_gate_driver_if.sv
// -----------------------------------------------------------------------------
// dab_gate_driver_if
// Bus between the DAB phase-shift pattern generator and the gate driver.
//   en      : gate enable (0 commands every leg OFF)
//   V1, V2  : signed bridge commands, 2'b01 = +1, 2'b00 = 0, 2'b11 = -1,
//             2'b10 is illegal
//   Sp, Ss  : primary / secondary gates,
//             [0] leg A high, [1] leg A low, [2] leg B high, [3] leg B low
//   fault   : illegal command detected
//   dt_busy : at least one leg is inside its dead time
// master = command source, slave = gate driver.
// -----------------------------------------------------------------------------
interface dab_gate_driver_if;
   logic       en;
   logic [1:0] V1;
   logic [1:0] V2;
   logic [3:0] Sp;
   logic [3:0] Ss;
   logic       fault;
   logic       dt_busy;

   modport master (output en, V1, V2, input Sp, Ss, fault, dt_busy);
   modport slave  (input en, V1, V2, output Sp, Ss, fault, dt_busy);
endinterface

// File: rtl/dab_gate_driver.sv
// -----------------------------------------------------------------------------
// dab_gate_driver
// Turns the three-level bridge commands V1/V2 into the eight gate signals of
// the primary and secondary full bridges, with dead-time insertion on each of
// the four half-bridge legs so high and low side never conduct together.
//
// Ports
//   clk : system clock, rising edge
//   rst : synchronous, active-low reset
//   bus : dab_gate_driver_if.slave (en, V1, V2 in; Sp, Ss, fault, dt_busy out)
//
// Parameters
//   DEADTIME : dead time in clk cycles, 1..255
//   CNT_W    : dead-time counter width, 2**CNT_W > DEADTIME
//
// Optional build macro
//   GATE_FAULT_LATCH_EN : fault becomes sticky and forces all eight gates OFF
//                         until reset. Without it, only the bridge carrying
//                         the illegal code is forced OFF, for as long as the
//                         code stays illegal.
//
// Leg index: 0 = primary A, 1 = primary B, 2 = secondary A, 3 = secondary B.
// -----------------------------------------------------------------------------
module dab_gate_driver #(
   parameter int DEADTIME = 8,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   dab_gate_driver_if.slave bus
);

   typedef enum logic [1:0] {
      LEG_OFF = 2'd0,
      LEG_HI  = 2'd1,
      LEG_LO  = 2'd2,
      LEG_DT  = 2'd3
   } leg_state_t;

   localparam logic [CNT_W-1:0] DT_LOAD      = CNT_W'(DEADTIME - 1);
   localparam logic [1:0]       CODE_ILLEGAL = 2'b10;

   logic             en_q;
   logic [1:0]       v1_q;
   logic [1:0]       v2_q;
   logic             fault_q;
   logic             fault_any;
   logic             kill_p;
   logic             kill_s;
   leg_state_t       leg_state [4];
   leg_state_t       leg_next  [4];
   leg_state_t       leg_want  [4];
   logic [CNT_W-1:0] leg_cnt   [4];
   logic [CNT_W-1:0] cnt_next  [4];

   // Desired leg state from a bridge code; leg B mirrors leg A so that
   // code 0 freewheels both legs on the low side.
   function automatic leg_state_t want_state(input logic [1:0] code,
                                             input logic       is_leg_b,
                                             input logic       force_off);
      leg_state_t w;
      if (force_off) begin
         w = LEG_OFF;
      end else begin
         case (code)
            2'b01:   w = is_leg_b ? LEG_LO : LEG_HI;
            2'b00:   w = LEG_LO;
            2'b11:   w = is_leg_b ? LEG_HI : LEG_LO;
            default: w = LEG_OFF;
         endcase
      end
      return w;
   endfunction

   // Input stage: register enable, commands and the illegal-code flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         en_q    <= 1'b0;
         v1_q    <= 2'b00;
         v2_q    <= 2'b00;
         fault_q <= 1'b0;
      end else begin
         en_q    <= bus.en;
         v1_q    <= bus.V1;
         v2_q    <= bus.V2;
         fault_q <= (bus.V1 == CODE_ILLEGAL) || (bus.V2 == CODE_ILLEGAL);
      end
   end

`ifdef GATE_FAULT_LATCH_EN
   logic fault_hold;

   // Sticky fault: once seen, only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fault_hold <= 1'b0;
      end else if (fault_q) begin
         fault_hold <= 1'b1;
      end else begin
         fault_hold <= fault_hold;
      end
   end

   assign fault_any = fault_q | fault_hold;
   assign kill_p    = !en_q | fault_any;
   assign kill_s    = !en_q | fault_any;
`else
   assign fault_any = fault_q;
   assign kill_p    = !en_q | (v1_q == CODE_ILLEGAL);
   assign kill_s    = !en_q | (v2_q == CODE_ILLEGAL);
`endif

   // Desired state of each leg from the registered commands.
   always_comb begin
      leg_want[0] = want_state(v1_q, 1'b0, kill_p);
      leg_want[1] = want_state(v1_q, 1'b1, kill_p);
      leg_want[2] = want_state(v2_q, 1'b0, kill_s);
      leg_want[3] = want_state(v2_q, 1'b1, kill_s);
   end

   // Leg FSM next state. Turning off is always immediate; a complementary
   // switch passes through DT, and DT always runs to completion unless the
   // leg is commanded OFF. On expiry the most recent desired state is taken.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         leg_next[i] = leg_state[i];
         cnt_next[i] = leg_cnt[i];
         case (leg_state[i])
            LEG_OFF: begin
               leg_next[i] = leg_want[i];
            end
            LEG_HI: begin
               if (leg_want[i] == LEG_LO) begin
                  leg_next[i] = LEG_DT;
                  cnt_next[i] = DT_LOAD;
               end else if (leg_want[i] == LEG_OFF) begin
                  leg_next[i] = LEG_OFF;
               end else begin
                  leg_next[i] = LEG_HI;
               end
            end
            LEG_LO: begin
               if (leg_want[i] == LEG_HI) begin
                  leg_next[i] = LEG_DT;
                  cnt_next[i] = DT_LOAD;
               end else if (leg_want[i] == LEG_OFF) begin
                  leg_next[i] = LEG_OFF;
               end else begin
                  leg_next[i] = LEG_LO;
               end
            end
            LEG_DT: begin
               if (leg_want[i] == LEG_OFF) begin
                  leg_next[i] = LEG_OFF;
                  cnt_next[i] = {CNT_W{1'b0}};
               end else if (leg_cnt[i] == {CNT_W{1'b0}}) begin
                  leg_next[i] = leg_want[i];
               end else begin
                  cnt_next[i] = leg_cnt[i] - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               leg_next[i] = LEG_OFF;
               cnt_next[i] = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Leg FSM state and dead-time counter registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            leg_state[i] <= LEG_OFF;
            leg_cnt[i]   <= {CNT_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            leg_state[i] <= leg_next[i];
            leg_cnt[i]   <= cnt_next[i];
         end
      end
   end

   // Gates are decoded straight from the registered leg states, so a leg can
   // only ever show one gate on.
   assign bus.Sp = {leg_state[1] == LEG_LO, leg_state[1] == LEG_HI,
                    leg_state[0] == LEG_LO, leg_state[0] == LEG_HI};
   assign bus.Ss = {leg_state[3] == LEG_LO, leg_state[3] == LEG_HI,
                    leg_state[2] == LEG_LO, leg_state[2] == LEG_HI};
   assign bus.fault   = fault_any;
   assign bus.dt_busy = (leg_state[0] == LEG_DT) | (leg_state[1] == LEG_DT) |
                        (leg_state[2] == LEG_DT) | (leg_state[3] == LEG_DT);

endmodule

// File: tb/tb_dab_gate_driver.sv
// -----------------------------------------------------------------------------
// tb_dab_gate_driver
// Self-checking bench for dab_gate_driver with DEADTIME = 4: a table of
// directed vectors, a hand-written fault sequence, then random commands
// compared against a timestamp-based reference model.
// -----------------------------------------------------------------------------
module tb_dab_gate_driver;

   localparam int DT = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   dab_gate_driver_if bus();

   dab_gate_driver #(.DEADTIME(DT), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;

   // Reference model: per leg, which gate conducts (0 none, 1 high, 2 low)
   // and the first edge at which a gate may be switched on again.
   logic       m_en_q     = 1'b0;
   logic [1:0] m_v1_q     = 2'b00;
   logic [1:0] m_v2_q     = 2'b00;
   logic       m_fault_q  = 1'b0;
   logic       m_latched  = 1'b0;
   int         m_cur [4]        = '{0, 0, 0, 0};
   int         m_dead_until [4] = '{0, 0, 0, 0};

   typedef struct {
      logic       r;
      logic       e;
      logic [1:0] a;
      logic [1:0] b;
      logic [3:0] sp;
      logic [3:0] ss;
      logic       f;
      logic       bsy;
   } vec_t;

   vec_t vt [33];

   function automatic int code_value(input logic [1:0] c);
      if (c == 2'b01) return 1;
      else if (c == 2'b11) return -1;
      else return 0;
   endfunction

   function automatic logic [3:0] m_gates(input int la, input int lb);
      return {lb == 2, lb == 1, la == 2, la == 1};
   endfunction

   function automatic logic m_busy();
      logic b = 1'b0;
      for (int i = 0; i < 4; i++)
         if (m_cur[i] == 0 && m_dead_until[i] > edge_n) b = 1'b1;
      return b;
   endfunction

   function automatic logic m_fault();
`ifdef GATE_FAULT_LATCH_EN
      return m_fault_q | m_latched;
`else
      return m_fault_q;
`endif
   endfunction

   task automatic model_edge(input logic r, input logic e,
                             input logic [1:0] a, input logic [1:0] b);
      int   w [4];
      logic off_p, off_s;
      int   vp, vs;
      edge_n++;
      if (!r) begin
         m_en_q = 1'b0; m_v1_q = 2'b00; m_v2_q = 2'b00;
         m_fault_q = 1'b0; m_latched = 1'b0;
         for (int i = 0; i < 4; i++) begin
            m_cur[i] = 0;
            m_dead_until[i] = 0;
         end
      end else begin
`ifdef GATE_FAULT_LATCH_EN
         off_p = !m_en_q || m_fault_q || m_latched;
         off_s = off_p;
`else
         off_p = !m_en_q || (m_v1_q == 2'b10);
         off_s = !m_en_q || (m_v2_q == 2'b10);
`endif
         vp = code_value(m_v1_q);
         vs = code_value(m_v2_q);
         w[0] = off_p ? 0 : ((vp > 0) ? 1 : 2);
         w[1] = off_p ? 0 : ((vp < 0) ? 1 : 2);
         w[2] = off_s ? 0 : ((vs > 0) ? 1 : 2);
         w[3] = off_s ? 0 : ((vs < 0) ? 1 : 2);
         for (int i = 0; i < 4; i++) begin
            if (w[i] == 0) begin
               m_cur[i] = 0;
               m_dead_until[i] = 0;
            end else if (m_cur[i] == 0) begin
               if (edge_n >= m_dead_until[i]) m_cur[i] = w[i];
            end else if (m_cur[i] != w[i]) begin
               m_cur[i] = 0;
               m_dead_until[i] = edge_n + DT;
            end
         end
         m_latched = m_latched | m_fault_q;
         m_en_q    = e;
         m_v1_q    = a;
         m_v2_q    = b;
         m_fault_q = (a == 2'b10) || (b == 2'b10);
      end
   endtask

   task automatic tick(input logic r, input logic e,
                       input logic [1:0] a, input logic [1:0] b);
      @(negedge clk);
      rst    = r;
      bus.en = e;
      bus.V1 = a;
      bus.V2 = b;
      @(posedge clk);
      model_edge(r, e, a, b);
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %b, expected %b", nm, edge_n, act, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input logic [3:0] sp, input logic [3:0] ss,
                              input logic f, input logic bsy);
      chk({tag, "_sp"}, bus.Sp, sp);
      chk({tag, "_ss"}, bus.Ss, ss);
      chk({tag, "_fault"}, {3'b000, bus.fault}, {3'b000, f});
      chk({tag, "_busy"}, {3'b000, bus.dt_busy}, {3'b000, bsy});
      chk({tag, "_shoot"}, {bus.Sp[0] & bus.Sp[1], bus.Sp[2] & bus.Sp[3],
                            bus.Ss[0] & bus.Ss[1], bus.Ss[2] & bus.Ss[3]}, 4'b0000);
   endtask

   initial begin
      logic [1:0] ra, rb;
      logic       rr, re;

      bus.en = 1'b0;
      bus.V1 = 2'b00;
      bus.V2 = 2'b00;

      //        rst   en    V1     V2     Sp       Ss       flt   busy
      vt[ 0] = '{1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[ 1] = '{1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[ 2] = '{1'b1, 1'b1, 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[ 3] = '{1'b1, 1'b1, 2'b00, 2'b00, 4'b1010, 4'b1010, 1'b0, 1'b0};
      vt[ 4] = '{1'b1, 1'b1, 2'b01, 2'b00, 4'b1010, 4'b1010, 1'b0, 1'b0};
      vt[ 5] = '{1'b1, 1'b1, 2'b01, 2'b00, 4'b1000, 4'b1010, 1'b0, 1'b1};
      vt[ 6] = '{1'b1, 1'b1, 2'b01, 2'b00, 4'b1000, 4'b1010, 1'b0, 1'b1};
      vt[ 7] = '{1'b1, 1'b1, 2'b01, 2'b00, 4'b1000, 4'b1010, 1'b0, 1'b1};
      vt[ 8] = '{1'b1, 1'b1, 2'b01, 2'b00, 4'b1000, 4'b1010, 1'b0, 1'b1};
      vt[ 9] = '{1'b1, 1'b1, 2'b01, 2'b00, 4'b1001, 4'b1010, 1'b0, 1'b0};
      vt[10] = '{1'b1, 1'b1, 2'b11, 2'b00, 4'b1001, 4'b1010, 1'b0, 1'b0};
      vt[11] = '{1'b1, 1'b1, 2'b11, 2'b00, 4'b0000, 4'b1010, 1'b0, 1'b1};
      vt[12] = '{1'b1, 1'b1, 2'b11, 2'b00, 4'b0000, 4'b1010, 1'b0, 1'b1};
      vt[13] = '{1'b1, 1'b1, 2'b11, 2'b00, 4'b0000, 4'b1010, 1'b0, 1'b1};
      vt[14] = '{1'b1, 1'b1, 2'b11, 2'b00, 4'b0000, 4'b1010, 1'b0, 1'b1};
      vt[15] = '{1'b1, 1'b1, 2'b11, 2'b00, 4'b0110, 4'b1010, 1'b0, 1'b0};
      vt[16] = '{1'b1, 1'b1, 2'b11, 2'b01, 4'b0110, 4'b1010, 1'b0, 1'b0};
      vt[17] = '{1'b1, 1'b1, 2'b11, 2'b01, 4'b0110, 4'b1000, 1'b0, 1'b1};
      vt[18] = '{1'b1, 1'b0, 2'b11, 2'b01, 4'b0110, 4'b1000, 1'b0, 1'b1};
      vt[19] = '{1'b1, 1'b0, 2'b11, 2'b01, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[20] = '{1'b1, 1'b1, 2'b01, 2'b01, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[21] = '{1'b1, 1'b1, 2'b01, 2'b01, 4'b1001, 4'b1001, 1'b0, 1'b0};
      vt[22] = '{1'b1, 1'b1, 2'b00, 2'b01, 4'b1001, 4'b1001, 1'b0, 1'b0};
      vt[23] = '{1'b1, 1'b1, 2'b01, 2'b01, 4'b1000, 4'b1001, 1'b0, 1'b1};
      vt[24] = '{1'b1, 1'b1, 2'b01, 2'b01, 4'b1000, 4'b1001, 1'b0, 1'b1};
      vt[25] = '{1'b1, 1'b1, 2'b01, 2'b01, 4'b1000, 4'b1001, 1'b0, 1'b1};
      vt[26] = '{1'b1, 1'b1, 2'b01, 2'b01, 4'b1000, 4'b1001, 1'b0, 1'b1};
      vt[27] = '{1'b1, 1'b1, 2'b01, 2'b01, 4'b1001, 4'b1001, 1'b0, 1'b0};
      vt[28] = '{1'b1, 1'b1, 2'b11, 2'b01, 4'b1001, 4'b1001, 1'b0, 1'b0};
      vt[29] = '{1'b1, 1'b1, 2'b11, 2'b01, 4'b0000, 4'b1001, 1'b0, 1'b1};
      vt[30] = '{1'b0, 1'b1, 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[31] = '{1'b1, 1'b1, 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vt[32] = '{1'b1, 1'b1, 2'b00, 2'b00, 4'b1010, 4'b1010, 1'b0, 1'b0};

      for (int i = 0; i < 33; i++) begin
         tick(vt[i].r, vt[i].e, vt[i].a, vt[i].b);
         chk_outputs($sformatf("vec%0d", i), vt[i].sp, vt[i].ss, vt[i].f, vt[i].bsy);
      end

      // One-cycle illegal code on V2.
      tick(1'b1, 1'b1, 2'b00, 2'b10);
      chk_outputs("flt_set", 4'b1010, 4'b1010, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 2'b00, 2'b00);
`ifdef GATE_FAULT_LATCH_EN
      chk_outputs("flt_off", 4'b0000, 4'b0000, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b1, 2'b00, 2'b00);
         chk_outputs("flt_hold", 4'b0000, 4'b0000, 1'b1, 1'b0);
      end
`else
      chk_outputs("flt_off", 4'b1010, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b1, 2'b00, 2'b00);
         chk_outputs("flt_resume", 4'b1010, 4'b1010, 1'b0, 1'b0);
      end
`endif
      tick(1'b0, 1'b1, 2'b00, 2'b00);
      chk_outputs("flt_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 2'b00, 2'b00);
      chk_outputs("flt_rel1", 4'b0000, 4'b0000, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 2'b00, 2'b00);
      chk_outputs("flt_rel2", 4'b1010, 4'b1010, 1'b0, 1'b0);

      // Random commands against the reference model.
      ra = 2'b00;
      rb = 2'b00;
      for (int n = 0; n < 3000; n++) begin
         rr = ($urandom_range(0, 199) != 0);
         re = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
               0:       ra = 2'b00;
               1:       ra = 2'b01;
               default: ra = 2'b11;
            endcase
         end
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
               0:       rb = 2'b00;
               1:       rb = 2'b01;
               default: rb = 2'b11;
            endcase
         end
         tick(rr, re,
              ($urandom_range(0, 149) == 0) ? 2'b10 : ra,
              ($urandom_range(0, 149) == 0) ? 2'b10 : rb);
         chk_outputs("rnd", m_gates(m_cur[0], m_cur[1]), m_gates(m_cur[2], m_cur[3]),
                     m_fault(), m_busy());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
